// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity codes and the
// baud divider helper used by both receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  // Clocks per oversample tick; clamped to 1 so a too-fast baud setting
  // still yields a legal divider instead of a zero-width counter.
  function automatic int uart_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  // NOTE: clocked state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with valid/ready output and per-frame status.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions
// (taken one tick later than the default single mid-bit sample).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int MID = OVERSAMPLE / 2;
`else
  localparam int MID = OVERSAMPLE / 2 - 1;
`endif
  localparam logic [SW-1:0] SAMP_MID  = SW'(MID);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic                 rx_meta, rxs;
  logic                 tick;
  logic                 bit_val;
  uart_rx_state_t       state, state_n;
  logic [SW-1:0]        samp_cnt, samp_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 par_acc, par_n;
  logic                 ferr, ferr_n;
  logic                 brk, brk_n;
  logic                 armed, armed_n;
  logic                 frame_done;
  logic                 perr_calc;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; resets low so the line is never armed before
  // the real pin level has propagated through.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rxs     <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Keep the two previous tick samples for the 2-of-3 vote.
  always_ff @(posedge clk) begin
    if (rst)       hist <= '0;
    else if (tick) hist <= {hist[0], rxs};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  // Parity verdict over data XOR parity bit accumulated in par_acc.
  assign perr_calc = (PARITY == UART_PAR_ODD)  ? ~par_acc :
                     (PARITY == UART_PAR_EVEN) ?  par_acc : 1'b0;

  // FSM and frame datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_acc   <= 1'b0;
      ferr      <= 1'b0;
      brk       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      samp_cnt  <= samp_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      par_acc   <= par_n;
      ferr      <= ferr_n;
      brk       <= brk_n;
      armed     <= armed_n;
    end
  end

  // Next-state logic; everything advances only on an oversample tick.
  // NOTE: every variable gets its hold value first, so no branch can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    samp_n     = samp_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift_reg;
    par_n      = par_acc;
    ferr_n     = ferr;
    brk_n      = brk;
    armed_n    = armed;
    frame_done = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (rxs) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n = ST_START;
            samp_n  = '0;
            bit_n   = '0;
            par_n   = 1'b0;
            ferr_n  = 1'b0;
            brk_n   = 1'b0;
          end
        end
        ST_START: begin
          samp_n = samp_cnt + 1'b1;
          if (samp_cnt == SAMP_MID && bit_val) begin
            state_n = ST_IDLE;
          end else if (samp_cnt == SAMP_LAST) begin
            state_n = ST_DATA;
            samp_n  = '0;
          end
        end
        ST_DATA: begin
          samp_n = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
          if (samp_cnt == SAMP_MID) begin
            shift_n = {bit_val, shift_reg[DATA_BITS-1:1]};
            par_n   = par_acc ^ bit_val;
            bit_n   = bit_cnt + 1'b1;
          end
          if (samp_cnt == SAMP_LAST && bit_cnt == BITS_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          samp_n = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
          if (samp_cnt == SAMP_MID) par_n = par_acc ^ bit_val;
          if (samp_cnt == SAMP_LAST) state_n = ST_STOP;
        end
        ST_STOP: begin
          samp_n = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
          if (samp_cnt == SAMP_MID) begin
            if (!bit_val) begin
              ferr_n = 1'b1;
              if (bit_cnt == '0 && shift_reg == '0) brk_n = 1'b1;
            end
            // Finish at the last stop mid-sample so back-to-back frames
            // are not missed; a bad stop leaves the line disarmed.
            if (bit_cnt == STOP_LAST) begin
              frame_done = 1'b1;
              state_n    = ST_IDLE;
              armed_n    = ~ferr_n;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= perr_calc;
          frame_err  <= ferr_n;
          break_det  <= brk_n;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E2 instance.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DIV = 1000000 / (9600 * 16);
  localparam int BIT = DIV * 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd8, rxd7;
  logic [7:0] rx_data8;
  logic [6:0] rx_data7;
  logic       rx_valid8, rx_valid7, rx_ready8, rx_ready7;
  logic       parity_err8, frame_err8, break_det8, overrun_err8;
  logic       parity_err7, frame_err7, break_det7, overrun_err7;

  int n_checks = 0;
  int n_fail   = 0;

  int         acc8 = 0, acc7 = 0, vcyc8 = 0, ovr8 = 0;
  logic [7:0] cap8;
  logic [6:0] cap7;
  logic [2:0] cflags8, cflags7;

  always #5 clk = ~clk;

  uart_rx_param u_dut8 (
    .clk(clk), .rst(rst), .rxd(rxd8), .rx_data(rx_data8), .rx_valid(rx_valid8),
    .rx_ready(rx_ready8), .parity_err(parity_err8), .frame_err(frame_err8),
    .break_det(break_det8), .overrun_err(overrun_err8)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut7 (
    .clk(clk), .rst(rst), .rxd(rxd7), .rx_data(rx_data7), .rx_valid(rx_valid7),
    .rx_ready(rx_ready7), .parity_err(parity_err7), .frame_err(frame_err7),
    .break_det(break_det7), .overrun_err(overrun_err7)
  );

  // Record handshakes and pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_valid8) vcyc8++;
    if (rx_valid8 && rx_ready8) begin
      acc8++;
      cap8    = rx_data8;
      cflags8 = {parity_err8, frame_err8, break_det8};
    end
    if (overrun_err8) ovr8++;
    if (rx_valid7 && rx_ready7) begin
      acc7++;
      cap7    = rx_data7;
      cflags7 = {parity_err7, frame_err7, break_det7};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a frame LSB first; glitch_bit >= 0 pulls that bit low for one tick
  // early in the bit, well away from any sampling point.
  task automatic send(input int sel, input logic [15:0] frame, input int nbits,
                      input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < BIT; c++) begin
        logic v;
        v = frame[i];
        if (i == glitch_bit && c >= DIV && c < 2 * DIV) v = 1'b0;
        if (sel == 7) rxd7 = v;
        else          rxd8 = v;
        step(1);
      end
    end
  endtask

  task automatic idle8(input int nbits);
    rxd8 = 1'b1;
    step(nbits * BIT);
  endtask

  int   a0, v0, o0;
  logic found;

  initial begin
    rst = 1'b1; rxd8 = 1'b1; rxd7 = 1'b1; rx_ready8 = 1'b1; rx_ready7 = 1'b1;
    step(4);
    check("rst_valid8", 32'(rx_valid8), 32'd0);
    check("rst_data8", 32'(rx_data8), 32'd0);
    check("rst_flags8", 32'({parity_err8, frame_err8, break_det8, overrun_err8}), 32'd0);
    check("rst_state8", 32'(u_dut8.state), 32'(ST_IDLE));
    check("rst_armed8", 32'(u_dut8.armed), 32'd0);
    check("rst_valid7", 32'(rx_valid7), 32'd0);
    rst = 1'b0;
    step(2 * BIT);

    // Plain 8N1 frame.
    a0 = acc8; v0 = vcyc8;
    send(8, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, -1);
    step(4);
    check("a5_accepted", 32'(acc8 - a0), 32'd1);
    check("a5_data", 32'(cap8), 32'hA5);
    check("a5_flags", 32'(cflags8), 32'd0);
    check("a5_valid_cycles", 32'(vcyc8 - v0), 32'd1);

    // 7E2: 0x55 has four ones, so even parity wants a 0 parity bit.
    a0 = acc7;
    send(7, {5'h1F, 2'b11, 1'b1, 7'h55, 1'b0}, 11, -1);
    rxd7 = 1'b1; step(2 * BIT);
    check("7e2_bad_accepted", 32'(acc7 - a0), 32'd1);
    check("7e2_bad_data", 32'(cap7), 32'h55);
    check("7e2_bad_flags", 32'(cflags7), 32'b100);
    send(7, {5'h1F, 2'b11, 1'b0, 7'h55, 1'b0}, 11, -1);
    rxd7 = 1'b1; step(2 * BIT);
    check("7e2_good_accepted", 32'(acc7 - a0), 32'd2);
    check("7e2_good_flags", 32'(cflags7), 32'b000);

    // Low stop bit, then the line stays low: no restart until it goes high.
    a0 = acc8;
    send(8, {6'h3F, 1'b0, 8'h3C, 1'b0}, 10, -1);
    step(3 * BIT);
    check("fe_accepted", 32'(acc8 - a0), 32'd1);
    check("fe_data", 32'(cap8), 32'h3C);
    check("fe_flags", 32'(cflags8), 32'b010);
    idle8(2);
    send(8, {6'h3F, 1'b0, 8'h00, 1'b0}, 10, -1);
    step(4);
    check("brk_accepted", 32'(acc8 - a0), 32'd2);
    check("brk_data", 32'(cap8), 32'h00);
    check("brk_flags", 32'(cflags8), 32'b011);
    idle8(2);

    // Short low pulse is a false start.
    a0 = acc8;
    rxd8 = 1'b0; step(4 * DIV);
    idle8(2);
    check("false_start_accepted", 32'(acc8 - a0), 32'd0);
    check("false_start_state", 32'(u_dut8.state), 32'(ST_IDLE));

    // One-tick glitch early in data bit 3 of 0xFF.
    send(8, {6'h3F, 1'b1, 8'hFF, 1'b0}, 10, 4);
    step(4);
    check("glitch_accepted", 32'(acc8 - a0), 32'd1);
    check("glitch_data", 32'(cap8), 32'hFF);
    idle8(1);

    // Overrun: consumer stalled.
    rx_ready8 = 1'b0;
    o0 = ovr8;
    send(8, {6'h3F, 1'b1, 8'h11, 1'b0}, 10, -1);
    step(4);
    check("ovr_first_valid", 32'(rx_valid8), 32'd1);
    check("ovr_first_data", 32'(rx_data8), 32'h11);
    send(8, {6'h3F, 1'b1, 8'h22, 1'b0}, 10, -1);
    step(4);
    check("ovr_pulses", 32'(ovr8 - o0), 32'd1);
    check("ovr_held_data", 32'(rx_data8), 32'h11);
    check("ovr_held_flags", 32'({rx_valid8, parity_err8, frame_err8, break_det8}), 32'b1000);

    // Ready raised exactly in the completion cycle: new word loads.
    found = 1'b0;
    fork
      send(8, {6'h3F, 1'b1, 8'h22, 1'b0}, 10, -1);
      begin
        for (int i = 0; i < 12 * BIT && !found; i++) begin
          step(1);
          if (u_dut8.frame_done) begin
            found = 1'b1;
            rx_ready8 = 1'b1;
            step(1);
            rx_ready8 = 1'b0;
          end
        end
      end
    join
    check("sync_ready_seen", 32'(found), 32'd1);
    check("sync_ready_data", 32'(rx_data8), 32'h22);
    check("sync_ready_valid", 32'(rx_valid8), 32'd1);
    check("sync_ready_no_ovr", 32'(ovr8 - o0), 32'd1);
    rx_ready8 = 1'b1;
    step(2);
    check("drain_valid", 32'(rx_valid8), 32'd0);
    idle8(1);

    // Reset mid-frame (halfway through data bit 4 of 0x5A).
    a0 = acc8; v0 = vcyc8;
    send(8, {6'h3F, 1'b1, 8'h5A, 1'b0}, 5, -1);
    rxd8 = 1'b1;
    step(BIT / 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_outputs",
          32'({rx_valid8, rx_data8, parity_err8, frame_err8, break_det8, overrun_err8}), 32'd0);
    check("midrst_state", 32'(u_dut8.state), 32'(ST_IDLE));
    idle8(12);
    check("midrst_no_valid", 32'(vcyc8 - v0), 32'd0);
    send(8, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10, -1);
    step(4);
    check("post_rst_accepted", 32'(acc8 - a0), 32'd1);
    check("post_rst_data", 32'(cap8), 32'h5A);
    check("post_rst_flags", 32'(cflags8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised second-generation UART receiver: oversampled, start-bit-validated serial-to-parallel conversion with configurable data width, parity and stop bits. It adds a valid/ready output handshake and per-frame error status. It sits between the asynchronous `rxd` pin and the byte-consuming logic (FIFO or command parser) in the UART subsystem.

## Interface
- `CLK_FREQ`, 1000000: system clock frequency, Hz.
- `BAUD_RATE`, 9600: line rate, bits/s.
- `OVERSAMPLE`, 16: ticks per bit. Even, ≥4.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `rx_data` out DATA_BITS: received word.
- `rx_valid` out 1: word and status available.
- `rx_ready` in 1: consumer accepts the word when `rx_valid && rx_ready`.
- `parity_err` out 1: parity mismatch on the held word. 0 when PARITY=0.
- `frame_err` out 1: a stop bit was sampled low on the held word.
- `break_det` out 1: held word is all zeros with a low first stop bit.
- `overrun_err` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- `rxd` passes through a 2-flop synchroniser. All decisions use the synchronised value `rxs`.
- Tick generator: `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)` (integer division). The counter is `$clog2(DIV)` bits wide and wraps at DIV-1, emitting a one-clock tick. The FSM advances only on ticks.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`. A sample counter (`$clog2(OVERSAMPLE)` bits) and a bit counter (`$clog2(DATA_BITS+1)` bits) run within each state.
- `IDLE`: wait for an armed line and `rxs=0` on a tick, then go to `START` with sample counter 0.
  - The line is armed after `rxs=1` has been seen on a tick since reset or since the last frame.
- `START`: at sample OVERSAMPLE/2-1, if `rxs=1`, the start is false; return to `IDLE` with no output. Otherwise continue. At sample OVERSAMPLE-1, go to `DATA`.
- `DATA`: sample at mid-bit (OVERSAMPLE/2-1) and shift into a DATA_BITS register, LSB first. After DATA_BITS bits:
  - go to `PARITY` if PARITY≠0,
  - else go to `STOP`.
- `PARITY`: sample at mid-bit and compute XOR of data and parity bit. Odd parity requires 1; even parity requires 0.
- `STOP`: sample each stop bit at mid-bit. Any low sample sets frame error. If the first stop bit is low and all data is zero, set break.
  - The frame completes at the mid-bit sample of the last stop bit; the FSM returns to `IDLE` then, not at bit end.
  - A completed frame with frame error leaves the line disarmed.
- Completion rules:
  - If `rx_valid=0`, or `rx_ready=1` in the same cycle: load `rx_data` and the three status flags, and set `rx_valid=1`.
  - Otherwise pulse `overrun_err`. The held word and flags are unchanged and the new frame is discarded.
- `rx_valid` clears on `rx_valid && rx_ready` unless a frame completes in the same cycle.
- Status flags change only on load.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `parity_err` = `frame_err` = `break_det` = `overrun_err` = 0.
  - FSM in `IDLE`, line disarmed, tick counter 0.
- Synchroniser latency is 2 clocks. Start detection has up to 1 tick of extra uncertainty.
- `rx_valid` rises 1 clock after the last stop-bit mid-sample tick.
- Reset asserted mid-frame aborts the frame immediately: no `rx_valid`, no error. After reset, `rxs=1` must be seen before a start is accepted.
- `overrun_err` lasts exactly 1 clock per dropped frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each mid-bit decision (start check, data, parity, stop) is the 2-of-3 majority of samples OVERSAMPLE/2-2, -1 and OVERSAMPLE/2. The decision is taken at sample OVERSAMPLE/2.
- Undefined: a single sample at OVERSAMPLE/2-1.
- Frame-level timing differs by at most 1 tick between the two builds.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum,
  - parity encoding constants `UART_PAR_NONE` / `UART_PAR_ODD` / `UART_PAR_EVEN`,
  - the `uart_div()` constant function.
- Sub-module `uart_baud_tick`, parameterised by DIV, with `clk`, `rst` and `tick` ports. It is reused by the transmitter.

## Test plan
Bench bit period is DIV*OVERSAMPLE clocks.
- Defaults, `rx_ready=1`, send 0xA5 8N1: `rx_data=0xA5`, `rx_valid` high for 1 clock, all flags 0.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x55 with parity bit 1: `parity_err=1`, `rx_data=0x55`. The same frame with parity bit 0 gives `parity_err=0`.
- Send 0x3C with stop bit forced low: `frame_err=1`. The next start is ignored until `rxd` returns high. Send 0x00 with low stop: `break_det=1`, `frame_err=1`.
- `rxd` low pulse of OVERSAMPLE/4 ticks: no `rx_valid`, FSM back in `IDLE`. With the majority macro, a 1-tick glitch at mid-bit of a data bit of 0xFF does not corrupt the word.
- `rx_ready=0`, send 0x11 then 0x22: 0x11 held, `overrun_err` pulses once, flags unchanged. With `rx_ready` asserted in the completion cycle of 0x22: 0x22 loaded, no overrun.
- Assert `rst` during data bit 4 of 0x5A for 1 clock: no `rx_valid`, all outputs 0. A subsequent 0x5A after idle-high is received correctly.
